// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared bus widths and the memory-bus sequencer state type
package cpu_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } bus_state_t;

endpackage

// File: rtl/ram_sp.sv
// rtl/ram_sp.sv - single-port synchronous RAM, write on we, read through RD_LAT registered stages
module ram_sp
  import cpu_pkg::*;
#(
  parameter int MEM_DEPTH = 256,
  parameter int RD_LAT    = 2
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  logic [DATA_W-1:0] mem  [MEM_DEPTH];
  logic [DATA_W-1:0] pipe [RD_LAT];
  logic              in_range;

  // Out-of-range addresses read as zero and never modify the array
  assign in_range = {1'b0, addr} < (ADDR_W + 1)'(MEM_DEPTH);

  always_ff @(posedge clk) begin
    if (we && in_range) begin
      mem[addr] <= din;
    end
    if (re) begin
      pipe[0] <= in_range ? mem[addr] : '0;
    end
    for (int i = 1; i < RD_LAT; i++) begin
      pipe[i] <= pipe[i-1];
    end
  end

  assign dout = pipe[RD_LAT-1];

endmodule

// File: rtl/mem_bus_ctrl.sv
// rtl/mem_bus_ctrl.sv - memory-bus sequencer: fixed-latency byte access to ram_sp, bus_ready level
// Optional I/O port decode at IO_ADDR when MEM_BUS_IO_EN is defined.
module mem_bus_ctrl
  import cpu_pkg::*;
#(
  parameter int MEM_DEPTH = 256,
  parameter int RD_LAT    = 2
`ifdef MEM_BUS_IO_EN
  , parameter logic [ADDR_W-1:0] IO_ADDR = 8'hFF
`endif
) (
  input  logic              clk,
  input  logic              reset_cycle,
  input  logic              req_rd,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              bus_ready,
  output logic              busy
`ifdef MEM_BUS_IO_EN
  , output logic [DATA_W-1:0] io_out,
  output logic              io_out_stb,
  input  logic [DATA_W-1:0] io_in
`endif
);

  generate
    if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_rd_lat
      $error("mem_bus_ctrl: RD_LAT must be in 1..4");
    end
  endgenerate

  localparam logic [2:0] LAT_LOAD = 3'(RD_LAT - 1);

  bus_state_t        state, state_nxt;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_wdata;
  logic              acc_wr;
  logic [2:0]        lat_cnt;
  logic              ram_we, ram_re;
  logic [DATA_W-1:0] ram_dout;
  logic              is_io;

`ifdef MEM_BUS_IO_EN
  assign is_io      = (acc_addr == IO_ADDR);
  assign io_out_stb = (state == ACCESS) && acc_wr && is_io;
`else
  assign is_io = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset_cycle) begin
    if (reset_cycle) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    case (state)
      IDLE: begin
        if (req_wr || req_rd) begin
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        if (acc_wr) begin
          ram_we    = !is_io;
          state_nxt = DONE;
        end else begin
          ram_re    = !is_io;
          state_nxt = (RD_LAT == 1) ? DONE : WAIT;
        end
      end
      WAIT: begin
        // lat_cnt reaches zero on this edge
        if (lat_cnt == 3'd1) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset_cycle) begin
    if (reset_cycle) begin
      rdata     <= '0;
      bus_ready <= 1'b0;
      busy      <= 1'b0;
      acc_addr  <= '0;
      acc_wdata <= '0;
      acc_wr    <= 1'b0;
      lat_cnt   <= '0;
`ifdef MEM_BUS_IO_EN
      io_out    <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          // Write wins when both requests arrive together; the read is dropped
          if (req_wr || req_rd) begin
            acc_addr  <= addr;
            acc_wdata <= wdata;
            acc_wr    <= req_wr;
            bus_ready <= 1'b0;
            busy      <= 1'b1;
          end
        end
        ACCESS: begin
          lat_cnt <= LAT_LOAD;
`ifdef MEM_BUS_IO_EN
          if (acc_wr && is_io) begin
            io_out <= acc_wdata;
          end
`endif
        end
        WAIT: begin
          lat_cnt <= lat_cnt - 3'd1;
        end
        DONE: begin
          if (!acc_wr) begin
`ifdef MEM_BUS_IO_EN
            rdata <= is_io ? io_in : ram_dout;
`else
            rdata <= ram_dout;
`endif
          end
          bus_ready <= 1'b1;
          busy      <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  ram_sp #(
    .MEM_DEPTH(MEM_DEPTH),
    .RD_LAT   (RD_LAT)
  ) u_ram (
    .clk (clk),
    .we  (ram_we),
    .re  (ram_re),
    .addr(acc_addr),
    .din (acc_wdata),
    .dout(ram_dout)
  );

endmodule
